wimax_frame_ctrl: RTL and testbench

- Block-level sequencer for the WiMAX PHY chain (PRBS randomizer -> FEC -> interleaver -> QPSK modulator).
- On each start request it does three things in order:
  - pulses load to reseed the randomizer;
  - streams exactly one block of source bits into the chain under a valid/ready handshake;
  - waits for the matching number of modulator symbols, then reports completion, or a timeout if the chain stalls.
- It replaces free-running load/enable generation with one explicit, restartable block schedule.

---
 rtl/wimax_ctrl_pkg.sv | 44 ++++
 rtl/wimax_stall_timer.sv | 52 +++++
 rtl/wimax_frame_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_wimax_frame_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wimax_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wimax_ctrl_pkg
// Shared types and default constants for the WiMAX PHY block sequencer.
//   ctrl_state_t      : sequencer states (IDLE, LOAD, STREAM, DRAIN, DONE)
//   *_DEF constants   : default block geometry, stall limit and counter widths
//   is_busy/is_active : state decode helpers shared by the sequencer
// -----------------------------------------------------------------------------
package wimax_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } ctrl_state_t;

    localparam int BLOCK_BITS_DEF    = 96;
    localparam int SYM_PER_BLOCK_DEF = 96;
    localparam int TIMEOUT_DEF       = 1023;
    localparam int CNT_W_DEF         = 8;
    localparam int TO_W_DEF          = 10;

    // Controller owns a block in progress (start requests are ignored here).
    function automatic logic is_busy(input ctrl_state_t s);
        logic r;
        case (s)
            LOAD, STREAM, DRAIN: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    // Chain is running: randomizer enabled and modulator symbols are counted.
    function automatic logic is_active(input ctrl_state_t s);
        logic r;
        case (s)
            STREAM, DRAIN: r = 1'b1;
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wimax_stall_timer.sv
// -----------------------------------------------------------------------------
// wimax_stall_timer
// Counts consecutive cycles without progress while the sequencer drains the
// chain. The count stops at TIMEOUT so 'expired' stays asserted until cleared.
//   clock   : chain bit clock
//   reset   : synchronous, active-low
//   clr     : restart the count from zero (takes priority over tick)
//   tick    : count one stalled cycle
//   expired : count has reached TIMEOUT
// -----------------------------------------------------------------------------
module wimax_stall_timer #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT_C = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] ONE_C   = TO_W'(1);
    localparam logic [TO_W-1:0] ZERO_C  = {TO_W{1'b0}};

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = ZERO_C;
        end else if (tick && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= ZERO_C;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT_C);

endmodule

// File: rtl/wimax_frame_ctrl.sv
// -----------------------------------------------------------------------------
// wimax_frame_ctrl
// Block sequencer for the WiMAX PHY chain (randomizer -> FEC -> interleaver ->
// QPSK). Each accepted start reseeds the randomizer, streams exactly one block
// of source bits, then waits for the matching number of modulator symbols or
// aborts when the chain stalls.
//   clock, reset             : bit clock, synchronous active-low reset
//   start                    : block request, honoured only in IDLE or DONE
//   src_data/valid/ready     : source side handshake
//   dut_load/enable          : randomizer seed pulse and enable
//   dut_in_data/valid/ready  : chain side handshake (pass-through in STREAM)
//   mod_valid                : modulator symbol strobe
//   busy, block_done         : status, done is a one-cycle pulse per block
//   timeout_err              : last block aborted on stall (sticky)
//   bits_sent, syms_rcvd     : progress counters of the current block
//   block_count              : blocks completed without abort (wraps)
// -----------------------------------------------------------------------------
module wimax_frame_ctrl
    import wimax_ctrl_pkg::*;
#(
    parameter int BLOCK_BITS    = BLOCK_BITS_DEF,
    parameter int SYM_PER_BLOCK = SYM_PER_BLOCK_DEF,
    parameter int TIMEOUT       = TIMEOUT_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int TO_W          = TO_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             src_data,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             dut_load,
    output logic             dut_enable,
    output logic             dut_in_data,
    output logic             dut_in_valid,
    input  logic             dut_in_ready,
    input  logic             mod_valid,
    output logic             busy,
    output logic             block_done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] bits_sent,
    output logic [CNT_W-1:0] syms_rcvd,
    output logic [15:0]      block_count
);

    localparam logic [CNT_W-1:0] ZERO_C      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
    localparam logic [CNT_W-1:0] BITS_LAST_C = CNT_W'(BLOCK_BITS - 1);
    localparam logic [CNT_W-1:0] SYM_FULL_C  = CNT_W'(SYM_PER_BLOCK);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] syms_q, syms_d;
    logic             terr_q, terr_d;
    logic [15:0]      bcnt_q, bcnt_d;
    logic             busy_q, load_q, enable_q, done_q;

    logic             xfer_s;
    logic             sym_hit_s;
    logic             timer_clr_s;
    logic             timer_tick_s;
    logic             timer_expired_s;

    // The stall count only runs in DRAIN; holding it clear elsewhere makes
    // every DRAIN entry start from zero.
    assign timer_clr_s  = (state_q != DRAIN) | mod_valid;
    assign timer_tick_s = (state_q == DRAIN);

    wimax_stall_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_stall_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (timer_clr_s),
        .tick    (timer_tick_s),
        .expired (timer_expired_s)
    );

    // Combinational handshake pass-through, open only while streaming.
    always_comb begin
        src_ready    = 1'b0;
        dut_in_valid = 1'b0;
        dut_in_data  = 1'b0;
        if (state_q == STREAM) begin
            src_ready    = dut_in_ready;
            dut_in_valid = src_valid;
            dut_in_data  = src_data;
        end else begin
            src_ready    = 1'b0;
            dut_in_valid = 1'b0;
            dut_in_data  = 1'b0;
        end
    end

    assign xfer_s    = (state_q == STREAM) & src_valid & dut_in_ready;
    assign sym_hit_s = is_active(state_q) & mod_valid & (syms_q != SYM_FULL_C);

    // Next-state and counter updates for the block schedule.
    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        terr_d  = terr_q;
        bcnt_d  = bcnt_q;
        if (sym_hit_s) begin
            syms_d = syms_q + ONE_C;
        end else begin
            syms_d = syms_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    bits_d  = ZERO_C;
                    syms_d  = ZERO_C;
                    terr_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (xfer_s) begin
                    bits_d = bits_q + ONE_C;
                    if (bits_q == BITS_LAST_C) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                // Completion is tested first so a same-cycle expiry is not
                // reported as an abort.
                if (syms_q == SYM_FULL_C) begin
                    state_d = DONE;
                end else if (timer_expired_s) begin
                    terr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (!terr_q) begin
                    bcnt_d = bcnt_q + 16'd1;
                end else begin
                    bcnt_d = bcnt_q;
                end
                if (start) begin
                    state_d = LOAD;
                    bits_d  = ZERO_C;
                    syms_d  = ZERO_C;
                    terr_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs (decoded from next state
    // so they line up with the state they describe).
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            bits_q   <= ZERO_C;
            syms_q   <= ZERO_C;
            terr_q   <= 1'b0;
            bcnt_q   <= 16'd0;
            busy_q   <= 1'b0;
            load_q   <= 1'b0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bits_q   <= bits_d;
            syms_q   <= syms_d;
            terr_q   <= terr_d;
            bcnt_q   <= bcnt_d;
            busy_q   <= is_busy(state_d);
            load_q   <= (state_d == LOAD);
            enable_q <= is_active(state_d);
            done_q   <= (state_d == DONE);
        end
    end

    assign busy        = busy_q;
    assign dut_load    = load_q;
    assign dut_enable  = enable_q;
    assign block_done  = done_q;
    assign timeout_err = terr_q;
    assign bits_sent   = bits_q;
    assign syms_rcvd   = syms_q;
    assign block_count = bcnt_q;

endmodule

// File: tb/tb_wimax_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wimax_frame_ctrl
// Directed scenarios for the WiMAX block sequencer. Stimulus pushes the expected
// bit stream and expected block results into queues; a monitor pops them when
// the DUT forwards a bit or pulses block_done.
// -----------------------------------------------------------------------------
module tb_wimax_frame_ctrl;

    localparam int NB = 96;
    localparam int NS = 96;
    localparam int TO = 1023;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        src_data;
    logic        src_valid;
    logic        src_ready;
    logic        dut_load;
    logic        dut_enable;
    logic        dut_in_data;
    logic        dut_in_valid;
    logic        dut_in_ready;
    logic        mod_valid;
    logic        busy;
    logic        block_done;
    logic        timeout_err;
    logic [7:0]  bits_sent;
    logic [7:0]  syms_rcvd;
    logic [15:0] block_count;
    logic [39:0] outs_s;

    always #5 clock = ~clock;

    wimax_frame_ctrl #(
        .BLOCK_BITS    (NB),
        .SYM_PER_BLOCK (NS),
        .TIMEOUT       (TO),
        .CNT_W         (8),
        .TO_W          (10)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .dut_load     (dut_load),
        .dut_enable   (dut_enable),
        .dut_in_data  (dut_in_data),
        .dut_in_valid (dut_in_valid),
        .dut_in_ready (dut_in_ready),
        .mod_valid    (mod_valid),
        .busy         (busy),
        .block_done   (block_done),
        .timeout_err  (timeout_err),
        .bits_sent    (bits_sent),
        .syms_rcvd    (syms_rcvd),
        .block_count  (block_count)
    );

    assign outs_s = {busy, block_done, timeout_err, dut_load, dut_enable,
                     src_ready, dut_in_valid, dut_in_data,
                     bits_sent, syms_rcvd, block_count};

    typedef struct {
        int bits;
        int syms;
        bit terr;
        int bc;
    } blk_t;

    blk_t exp_blk[$];
    bit   exp_bits[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // scenario bookkeeping (main process only)
    int blk_id   = 0;
    int bc_model = 0;
    int src_idx;
    int loads, xfers, stream_cyc, beats, last_beat, t_terr;
    bit done_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic bit pat(input int b, input int i);
        return (((i * 5 + b * 3) % 7) < 3);
    endfunction

    // ---------------- monitor ----------------
    bit   done_prev = 1'b0;
    bit   bc_pend   = 1'b0;
    int   bc_pend_val;

    always @(negedge clock) begin
        bit   b;
        blk_t e;
        if (bc_pend) begin
            chk("block_count", block_count, bc_pend_val);
            bc_pend = 1'b0;
        end
        if (dut_in_valid && dut_in_ready) begin
            if (exp_bits.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_bit: actual extra transfer, required none");
            end else begin
                b = exp_bits.pop_front();
                chk("in_data", dut_in_data, b);
            end
        end
        if (block_done) begin
            chk("done_single", done_prev, 1'b0);
            if (exp_blk.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: actual block_done, required none");
            end else begin
                e = exp_blk.pop_front();
                chk("bits_sent", bits_sent, e.bits);
                chk("syms_rcvd", syms_rcvd, e.syms);
                chk("timeout_err", timeout_err, e.terr);
                bc_pend     = 1'b1;
                bc_pend_val = e.bc;
            end
        end
        done_prev = block_done;
    end

    // ---------------- block driver ----------------
    // toggle: dut_in_ready flips every cycle; rdy0: its first value;
    // mod_start: cycle index of first mod_valid; b2b: keep start high;
    // poke: pulse start for 3 cycles in DRAIN; cont: first cycle is LOAD.
    task automatic run_block(input bit toggle, input bit rdy0, input int mod_start,
                             input int n_beats, input bit b2b, input bit poke,
                             input bit cont);
        blk_t e;
        int   k;
        int   pokes;
        bit   fire;
        bit   in_stream;
        blk_id++;
        for (int i = 0; i < NB; i++) exp_bits.push_back(pat(blk_id, i));
        e.bits = NB;
        e.syms = (n_beats > NS) ? NS : n_beats;
        e.terr = (n_beats < NS);
        if (!e.terr) bc_model = (bc_model + 1) % 65536;
        e.bc = bc_model;
        exp_blk.push_back(e);

        src_idx = 0; src_data = pat(blk_id, 0); src_valid = 1'b1;
        dut_in_ready = rdy0; start = 1'b1;
        loads = 0; xfers = 0; stream_cyc = 0; beats = 0;
        last_beat = -1; t_terr = -1; done_seen = 1'b0; pokes = 0; k = 0;
        while (!done_seen && k < 4000) begin
            mod_valid = (k >= mod_start) && (beats < n_beats);
            @(negedge clock);
            if (cont && k == 0) begin
                chk("b2b_load", dut_load, 1'b1);
                chk("b2b_bits_clr", bits_sent, 0);
                chk("b2b_syms_clr", syms_rcvd, 0);
            end
            in_stream = (loads > 0) && !dut_load && (xfers < NB);
            if (in_stream) stream_cyc++;
            chk("src_ready", src_ready, in_stream ? dut_in_ready : 1'b0);
            if (dut_load) loads++;
            fire = src_valid && src_ready;
            if (fire) xfers++;
            if (mod_valid) begin beats++; last_beat = k; end
            if (timeout_err && t_terr < 0) t_terr = k;
            if (block_done) done_seen = 1'b1;
            @(posedge clock); #1;
            if (poke && xfers == NB && pokes < 3) begin
                start = 1'b1; pokes++;
            end else begin
                start = b2b;
            end
            if (fire) begin src_idx++; src_data = pat(blk_id, src_idx); end
            if (toggle) dut_in_ready = ~dut_in_ready;
            k++;
        end
        chk("block_finished", done_seen, 1'b1);
        mod_valid = 1'b0;
        src_valid = 1'b0;
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        bit seen40;
        bit fire2;
        reset = 1'b0; start = 1'b0; src_data = 1'b0; src_valid = 1'b0;
        dut_in_ready = 1'b0; mod_valid = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("reset_outputs", outs_s, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // mod_valid in IDLE must not be counted
        mod_valid = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("idle_syms", syms_rcvd, 0);
            chk("idle_busy", busy, 1'b0);
            @(posedge clock); #1;
        end
        mod_valid = 1'b0;

        // nominal block
        run_block(1'b0, 1'b1, 20, 96, 1'b0, 1'b0, 1'b0);
        chk("nom_load_cycles", loads, 1);
        chk("nom_transfers", xfers, NB);
        @(negedge clock);
        chk("nom_back_idle", busy, 1'b0);
        @(posedge clock); #1;

        // backpressure: ready low on the first STREAM cycle, so 192 cycles
        run_block(1'b1, 1'b0, 20, 96, 1'b0, 1'b0, 1'b0);
        chk("bp_transfers", xfers, NB);
        chk("bp_stream_cycles", stream_cyc, 192);

        // stall abort: 50 beats in DRAIN. 1023 silent cycles are tolerated,
        // the 1024th sees the limit and the flag shows one cycle later.
        run_block(1'b0, 1'b1, 110, 50, 1'b0, 1'b0, 1'b0);
        chk("stall_beats", beats, 50);
        chk("stall_delay", t_terr - last_beat, TO + 2);

        // back-to-back: start held across DONE
        run_block(1'b0, 1'b1, 20, 96, 1'b1, 1'b0, 1'b0);
        run_block(1'b0, 1'b1, 20, 96, 1'b0, 1'b0, 1'b1);
        chk("b2b_load_cycles", loads, 1);
        start = 1'b0;

        // reset mid-stream
        blk_id++;
        for (int i = 0; i < NB; i++) exp_bits.push_back(pat(blk_id, i));
        src_idx = 0; src_data = pat(blk_id, 0); src_valid = 1'b1;
        dut_in_ready = 1'b1; start = 1'b1; seen40 = 1'b0;
        for (int k = 0; k < 200 && !seen40; k++) begin
            @(negedge clock);
            seen40 = (bits_sent == 8'd40);
            fire2  = src_valid && src_ready;
            @(posedge clock); #1;
            start = 1'b0;
            if (fire2) begin src_idx++; src_data = pat(blk_id, src_idx); end
        end
        chk("reached_40", seen40, 1'b1);
        reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("midreset_outputs", outs_s, 0);
        @(posedge clock); #1;
        reset = 1'b1; src_valid = 1'b0;
        exp_bits.delete();
        bc_model = 0;

        // clean block after reset; start pokes in DRAIN, extra beats saturate
        run_block(1'b0, 1'b1, 20, 100, 1'b0, 1'b1, 1'b0);
        chk("poke_load_cycles", loads, 1);
        chk("poke_transfers", xfers, NB);

        repeat (2) @(negedge clock);
        chk("bits_queue_empty", exp_bits.size(), 0);
        chk("blk_queue_empty", exp_blk.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
